// File: rtl/comparator_conditioner.sv
// Comparator front end: 2-FF synchronisers, per-channel persistence filters, glitch counter,
// sync ordering checker and (with COMP_COND_WATCHDOG_EN defined) a sync-loss watchdog.
module comparator_conditioner #(
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned WD_TIMEOUT = 2000000,
  parameter int unsigned GCNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              lsync_raw,
  input  logic              rsync_raw,
  input  logic              sig_raw,
  input  logic              glitch_clr,
  output logic              lsync,
  output logic              rsync,
  output logic              sig,
  output logic [GCNT_W-1:0] glitch_count,
  output logic              sync_lost,
  output logic              sync_seq_err,
  output logic [1:0]        seq_state
);

  // Channel index: 0 = left sync, 1 = right sync, 2 = groove signal.
  localparam logic [7:0]        FILT_LAST = 8'(FILT_LEN - 1);
  localparam logic [GCNT_W-1:0] GCNT_SAT  = '1;

  typedef enum logic [1:0] {
    ST_NONE   = 2'd0,
    ST_LAST_L = 2'd1,
    ST_LAST_R = 2'd2
  } seq_state_e;

  logic [2:0]        raw;
  logic [2:0]        sync1_q;
  logic [2:0]        sync2_q;
  logic [2:0]        filt_q, filt_d;
  logic [7:0]        cnt_q [3];
  logic [7:0]        cnt_d [3];
  logic [2:0]        glitch_ev;
  logic [1:0]        ev_sum;
  logic [GCNT_W+1:0] gsum;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic [1:0]        prev_q;
  logic              fall_l, fall_r;
  seq_state_e        state_q, state_d;
  logic              seq_err_q, seq_err_d;

  assign raw = {sig_raw, rsync_raw, lsync_raw};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      prev_q  <= '0;
      gcnt_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= 8'd0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= filt_q[1:0];
      gcnt_q  <= gcnt_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A level that disappears before the counter completes is a glitch.
  always_comb begin
    filt_d    = filt_q;
    glitch_ev = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = 8'd0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == FILT_LAST) filt_d[i] = sync2_q[i];
        else                       cnt_d[i] = cnt_q[i] + 8'd1;
      end else begin
        glitch_ev[i] = (cnt_q[i] != 8'd0);
      end
    end
  end

  assign ev_sum = {1'b0, glitch_ev[0]} + {1'b0, glitch_ev[1]} + {1'b0, glitch_ev[2]};
  assign gsum   = {2'b00, gcnt_q} + (GCNT_W + 2)'(ev_sum);

  always_comb begin
    gcnt_d = gsum[GCNT_W-1:0];
    if (glitch_clr)                        gcnt_d = '0;
    else if (gsum > {2'b00, GCNT_SAT})     gcnt_d = GCNT_SAT;
  end

  assign fall_l = prev_q[0] & ~filt_q[0];
  assign fall_r = prev_q[1] & ~filt_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_NONE;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_err_q <= seq_err_d;
    end
  end

  // Simultaneous falls leave the state alone; the fault pulse still fires.
  always_comb begin
    state_d = state_q;
    if (fall_l && !fall_r)      state_d = ST_LAST_L;
    else if (fall_r && !fall_l) state_d = ST_LAST_R;
  end

  always_comb begin
    seq_err_d = (fall_l && fall_r)
             || (fall_l && state_q == ST_LAST_L)
             || (fall_r && state_q == ST_LAST_R);
  end

`ifdef COMP_COND_WATCHDOG_EN
  localparam logic [31:0] WD_LIMIT = 32'(WD_TIMEOUT);

  logic [31:0] wd_q, wd_d;
  logic        lost_q, lost_d;

  // A falling edge in the timeout cycle wins over setting the flag.
  always_comb begin
    wd_d   = (wd_q == WD_LIMIT) ? wd_q : wd_q + 32'd1;
    lost_d = lost_q;
    if (fall_l || fall_r) begin
      wd_d   = 32'd0;
      lost_d = 1'b0;
    end else if (wd_d == WD_LIMIT) begin
      lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q   <= 32'd0;
      lost_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      lost_q <= lost_d;
    end
  end

  assign sync_lost = lost_q;
`else
  logic unused_wd;
  assign unused_wd = ^32'(WD_TIMEOUT);
  assign sync_lost = 1'b0;
`endif

  assign lsync        = filt_q[0];
  assign rsync        = filt_q[1];
  assign sig          = filt_q[2];
  assign glitch_count = gcnt_q;
  assign sync_seq_err = seq_err_q;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_comparator_conditioner.sv
// Directed bench for comparator_conditioner: filter latency, glitch counting and saturation,
// sync ordering faults, watchdog and mid-operation reset.
module tb_comparator_conditioner;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic lsync_raw = 1'b0;
  logic rsync_raw = 1'b0;
  logic sig_raw = 1'b0;
  logic glitch_clr = 1'b0;

  logic        lsync, rsync, sig, sync_lost, sync_seq_err;
  logic [3:0]  glitch_count;
  logic [1:0]  seq_state;

  logic        lsync1, rsync1, sig1, sync_lost1, sync_seq_err1;
  logic [15:0] glitch_count1;
  logic [1:0]  seq_state1;

  int checks = 0;
  int errors = 0;

  comparator_conditioner #(.FILT_LEN(4), .WD_TIMEOUT(100), .GCNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .lsync_raw(lsync_raw), .rsync_raw(rsync_raw),
    .sig_raw(sig_raw), .glitch_clr(glitch_clr), .lsync(lsync), .rsync(rsync), .sig(sig),
    .glitch_count(glitch_count), .sync_lost(sync_lost), .sync_seq_err(sync_seq_err),
    .seq_state(seq_state)
  );

  comparator_conditioner #(.FILT_LEN(1), .WD_TIMEOUT(100), .GCNT_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .lsync_raw(lsync_raw), .rsync_raw(rsync_raw),
    .sig_raw(sig_raw), .glitch_clr(glitch_clr), .lsync(lsync1), .rsync(rsync1), .sig(sig1),
    .glitch_count(glitch_count1), .sync_lost(sync_lost1), .sync_seq_err(sync_seq_err1),
    .seq_state(seq_state1)
  );

  // Clock and time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a clean sync pulse and watches the ordering-fault pulse after the raw fall.
  task automatic sync_fall(input string tag, input logic l, input logic r,
                           input int exp_pulses, input logic [1:0] exp_state);
    int pulses;
    int first;
    pulses = 0;
    first  = 0;
    lsync_raw = l;
    rsync_raw = r;
    tick(8);
    lsync_raw = 1'b0;
    rsync_raw = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (sync_seq_err) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    check({tag, "_pulses"}, pulses, exp_pulses);
    if (exp_pulses > 0) check({tag, "_edge"}, first, 7);
    check({tag, "_state"}, seq_state, exp_state);
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_lsync", lsync, 0);
    check("rst_rsync", rsync, 0);
    check("rst_sig", sig, 0);
    check("rst_gcnt", glitch_count, 0);
    check("rst_lost", sync_lost, 0);
    check("rst_err", sync_seq_err, 0);
    check("rst_state", seq_state, 0);
    reset_n = 1'b1;

    // Watchdog with no sync activity, then cleared by a left fall
    tick(99);
    check("wd_before", sync_lost, 0);
    tick(1);
`ifdef COMP_COND_WATCHDOG_EN
    check("wd_set", sync_lost, 1);
`else
    check("wd_off", sync_lost, 0);
`endif
    lsync_raw = 1'b1;
    tick(8);
    lsync_raw = 1'b0;
    tick(6);
`ifdef COMP_COND_WATCHDOG_EN
    check("wd_hold", sync_lost, 1);
`else
    check("wd_hold_off", sync_lost, 0);
`endif
    tick(1);
    check("wd_clear", sync_lost, 0);

    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);

    // Clean edge: rise and fall 6 edges after the first sampling edge
    sig_raw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) check("f1_rise_early", sig1, 0);
      if (k == 3) check("f1_rise", sig1, 1);
      if (k == 5) check("rise_early", sig, 0);
      if (k == 6) check("rise", sig, 1);
    end
    tick(14);
    sig_raw = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) check("fall_early", sig, 1);
      if (k == 6) check("fall", sig, 0);
    end
    check("clean_gcnt", glitch_count, 0);

    // Glitches: left 3 cycles, right and sig 2 cycles starting together
    lsync_raw = 1'b1;
    rsync_raw = 1'b1;
    sig_raw   = 1'b1;
    tick(2);
    rsync_raw = 1'b0;
    sig_raw   = 1'b0;
    tick(1);
    lsync_raw = 1'b0;
    tick(2);
    check("glitch_two", glitch_count, 2);
    tick(1);
    check("glitch_three", glitch_count, 3);
    tick(4);
    check("glitch_l", lsync, 0);
    check("glitch_r", rsync, 0);
    check("glitch_s", sig, 0);
    check("f1_gcnt", glitch_count1, 0);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    check("glitch_clr", glitch_count, 0);

    // Saturation at 15 with a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      sig_raw = 1'b1;
      tick(2);
      sig_raw = 1'b0;
      tick(3);
      if (i == 9) check("sat_mid", glitch_count, 10);
    end
    tick(6);
    check("sat", glitch_count, 15);
    check("sat_sig", sig, 0);

    // Sequencing
    sync_fall("seq_l", 1'b1, 1'b0, 0, 2'd1);
    sync_fall("seq_r", 1'b0, 1'b1, 0, 2'd2);
    sync_fall("seq_rr", 1'b0, 1'b1, 1, 2'd2);
    sync_fall("seq_lr", 1'b1, 1'b1, 1, 2'd2);

    // Reset while the left output is high
    lsync_raw = 1'b1;
    tick(8);
    check("pre_rst_lsync", lsync, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_lsync", lsync, 0);
    check("mid_rst_gcnt", glitch_count, 0);
    check("mid_rst_state", seq_state, 0);
    check("mid_rst_lost", sync_lost, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) check("f1_rst_early", lsync1, 0);
      if (k == 3) check("f1_rst_rise", lsync1, 1);
      if (k == 5) check("rst_rise_early", lsync, 0);
      if (k == 6) check("rst_rise", lsync, 1);
    end
    lsync_raw = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
